// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the fetch PC, issues imem requests and holds one instruction for decode.
// Optional PC_SEQ_STATS_EN adds fetch/squash counters on fetch_cnt_o and squash_cnt_o.
module pc_sequencer #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic              ex_branch_i,
  input  logic              ex_jump_i,
  input  logic              ex_brtaken_i,
  input  logic [AWIDTH-1:0] ex_target_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              insn_valid_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  input  logic              insn_ready_i,
  output logic              misalign_o,
  output logic [2:0]        state_o
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       squash_cnt_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH-1:0]   out_addr_q, out_addr_d;
  logic                valid_q, valid_d;
  logic [DWIDTH-1:0]   insn_q, insn_d;
  logic [AWIDTH-1:0]   pc_out_q, pc_out_d;
  logic                misalign_q, misalign_d;
  logic                req_q;
  logic                redirect;
  logic [AWIDTH-1:0]   target;
  logic                fetch_inc;
  logic                squash_inc;

  assign redirect = ex_valid_i && (ex_jump_i || (ex_branch_i && ex_brtaken_i));
  assign target   = ex_target_i & ~AWIDTH'(1);

  // Handshakes: imem request transfers when imem_req_o && imem_gnt_i; a response is one
  // imem_rvalid_i pulse; decode consumes the held word when insn_valid_o && insn_ready_i.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_addr_d = out_addr_q;
    valid_d    = valid_q;
    insn_d     = insn_q;
    pc_out_d   = pc_out_q;
    misalign_d = misalign_q | (redirect & ex_target_i[1]);
    fetch_inc  = 1'b0;
    squash_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = target;
      end
      S_REQ: begin
        if (imem_gnt_i) out_addr_d = pc_q;
        if (redirect) begin
          pc_d = target;
          if (imem_gnt_i) state_d = S_DROP;
        end else if (imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target;
          if (imem_rvalid_i) begin
            state_d    = S_REQ;
            squash_inc = 1'b1;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_rvalid_i) begin
          valid_d  = 1'b1;
          insn_d   = imem_rdata_i;
          pc_out_d = out_addr_q;
          pc_d     = pc_q + AWIDTH'(4);
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          // A consumed instruction still counts as fetched; downstream squashes it.
          pc_d       = target;
          valid_d    = 1'b0;
          state_d    = S_REQ;
          fetch_inc  = insn_ready_i;
          squash_inc = ~insn_ready_i;
        end else if (insn_ready_i) begin
          valid_d   = 1'b0;
          state_d   = S_REQ;
          fetch_inc = 1'b1;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = target;
        if (imem_rvalid_i) begin
          squash_inc = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= BASEADDR;
      out_addr_q <= BASEADDR;
      valid_q    <= 1'b0;
      insn_q     <= '0;
      pc_out_q   <= BASEADDR;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_addr_q <= out_addr_d;
      valid_q    <= valid_d;
      insn_q     <= insn_d;
      pc_out_q   <= pc_out_d;
      misalign_q <= misalign_d;
      req_q      <= (state_d == S_REQ);
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign insn_valid_o = valid_q;
  assign insn_o       = insn_q;
  assign pc_o         = pc_out_q;
  assign misalign_o   = misalign_q;
  assign state_o      = state_q;

`ifdef PC_SEQ_STATS_EN
  logic [31:0] fetch_cnt_q, squash_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (fetch_inc)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (squash_inc) squash_cnt_q <= squash_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = fetch_inc ^ squash_inc;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program counter sequencer for the pd3 core. It owns the architectural fetch PC and issues instruction-memory requests over a request/grant/response handshake. It presents fetched instructions to decode through a valid/ready register. It also consumes the branch/jump resolution produced by the execute stage: the taken flag and the ALU-computed target. Redirects squash in-flight or held fetches and restart fetch at the target.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, instruction width
- `BASEADDR`, 32'h0100_0000, PC value loaded at reset
- `clk` input 1 — the single clock; all state updates on its rising edge.
- `reset` input 1 — asynchronous, active-low reset.
- `ex_valid_i` input 1 — execute stage has a resolved control-flow instruction this cycle
- `ex_branch_i` input 1 — resolved instruction is a conditional branch
- `ex_jump_i` input 1 — resolved instruction is JAL/JALR
- `ex_brtaken_i` input 1 — branch condition outcome from the ALU
- `ex_target_i` input AWIDTH — redirect target computed by the ALU
- `imem_req_o` output 1 — fetch request valid
- `imem_addr_o` output AWIDTH — fetch address
- `imem_gnt_i` input 1 — memory accepts the request this cycle
- `imem_rvalid_i` input 1 — response data valid
- `imem_rdata_i` input DWIDTH — response instruction word
- `insn_valid_o` output 1 — instruction held for decode
- `insn_o` output DWIDTH — held instruction
- `pc_o` output AWIDTH — PC of the held instruction
- `insn_ready_i` input 1 — decode consumes the held instruction this cycle
- `misalign_o` output 1 — sticky flag: a redirect target had bit 1 set

## Operation
- A redirect fires when `ex_valid_i && (ex_jump_i || (ex_branch_i && ex_brtaken_i))`.
- A not-taken branch has no effect.
- The new PC is `ex_target_i` with bit 0 cleared.
  - If bit 1 of the target is set, `misalign_o` sets. It is cleared only by reset.
  - The PC is still loaded unchanged (no bit-1 correction).
- PC increment is `+4` modulo 2^AWIDTH, so 0xFFFF_FFFC wraps to 0.
- The FSM has five states: IDLE, REQ, WAIT, DROP, HOLD.
  - **IDLE**: entered only from reset. Goes to REQ on the next clock.
  - **REQ**: `imem_req_o`=1 and `imem_addr_o`=pc_q.
    - If `imem_gnt_i`=1, the outstanding address is latched and the FSM moves to WAIT.
    - Address and request stay stable until granted. The only exception is a redirect.
  - **WAIT**: on `imem_rvalid_i`, the output register loads (`insn_o`=rdata, `pc_o`=outstanding address, `insn_valid_o`=1), pc_q += 4, and the FSM moves to HOLD.
  - **HOLD**: when `insn_ready_i`=1, `insn_valid_o` clears next cycle and the FSM moves to REQ.
  - **DROP**: wait for `imem_rvalid_i`, discard the data, then go to REQ. `insn_valid_o` stays 0.
- Redirect behaviour by state (redirect has priority over the normal transition in every case):
  - **IDLE, or REQ without grant**: pc_q is replaced. The next-cycle request uses the target.
  - **REQ with `imem_gnt_i`=1 in the same cycle**: the old request becomes outstanding. pc_q is set to the target and the FSM goes to DROP.
  - **WAIT without rvalid**: go to DROP with pc_q set to the target.
  - **WAIT with rvalid in the same cycle**: the data is discarded and the FSM goes to REQ.
  - **HOLD**: `insn_valid_o` clears next cycle and the FSM goes to REQ.
    - If `insn_ready_i`=1 in the same cycle, the handshake still counts as completed. Squashing the consumed instruction is downstream's job.
- At most one memory request is outstanding at any time.

## Timing
- **Reset values**:
  - `imem_req_o`=0, `imem_addr_o`=BASEADDR
  - `insn_valid_o`=0, `insn_o`=0, `pc_o`=BASEADDR
  - `misalign_o`=0
  - state=IDLE, pc_q=BASEADDR
  - Stat counters, when present, are 0.
- First `imem_req_o`=1 occurs in the first cycle after reset deasserts.
- With zero-wait memory (grant in REQ, rvalid the next cycle) and decode always ready:
  - one instruction per 3 cycles (REQ, WAIT, HOLD);
  - `insn_valid_o` rises 2 cycles after the request cycle.
- Redirect-to-request latency: 1 cycle, or after the pending response when passing through DROP.
- Reset asserted mid-operation aborts immediately. Any later response to the aborted request must not arrive; the memory shares the same reset.
- All outputs are registered except `imem_addr_o`, which equals pc_q.

## Configuration
- **`PC_SEQ_STATS_EN`** defined: adds 32-bit outputs `fetch_cnt_o` and `squash_cnt_o`.
  - `fetch_cnt_o` increments on each completed decode handshake.
  - `squash_cnt_o` increments on each discarded response or squashed held instruction.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Reset release, zero-wait memory, ready=1**: `imem_addr_o` sequence 0x0100_0000, 0x0100_0004, 0x0100_0008. `pc_o` matches each and `insn_o` equals memory contents, one instruction every 3 cycles.
- **Taken branch in WAIT**, target 0x0100_0040, rvalid 2 cycles later: response dropped, `insn_valid_o` stays 0, next request at 0x0100_0040.
- **Redirect and grant in the same REQ cycle**: FSM passes through DROP. Exactly one discarded response, then a request at the target.
- **Decode backpressure** (`insn_ready_i`=0 for 5 cycles): `insn_o`/`pc_o` stable and no new `imem_req_o`. A JALR to 0x0100_0013 in HOLD gives PC 0x0100_0012 and `misalign_o`=1.
- **Not-taken branch** (`ex_branch_i`=1, `ex_brtaken_i`=0): fetch sequence unaltered. PC 0xFFFF_FFFC followed by a fetch at 0x0000_0000 (wrap).
- **`reset` asserted while in HOLD**: all outputs return to reset values asynchronously. Under `PC_SEQ_STATS_EN`, counters read 0.
